// File: rtl/input_buffer_pkg.sv
// input_buffer_pkg: shared constants and state encoding for the router
// input buffer.
//   TAM_FLIT   - flit width in bits
//   TAM_BUFFER - FIFO depth in flits (power of 2, minimum 2)
//   NPORT      - ports per router (EAST, WEST, NORTH, SOUTH, LOCAL)
//   buf_state_t - packet FSM states of the input buffer
`timescale 1ns/1ps
package input_buffer_pkg;

    localparam int TAM_FLIT   = 16;
    localparam int TAM_BUFFER = 4;
    localparam int NPORT      = 5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_HDR     = 3'd2,
        S_SIZE    = 3'd3,
        S_PAYLOAD = 3'd4,
        S_END     = 3'd5
    } buf_state_t;

endpackage

// File: rtl/input_buffer_fifo.sv
// input_buffer_fifo: circular flit storage for one router input port.
// Ports:
//   clock, reset  - rising-edge clock, async active-low reset
//   i_push/i_data - write request and flit; ignored while full
//   i_pop         - remove the head flit; ignored while empty
//   o_head        - flit at the read pointer (no bypass of the write path)
//   o_count       - flits stored, 0..DEPTH
//   o_credit      - space available
`timescale 1ns/1ps
module input_buffer_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_credit
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_credit = (r_count < CW'(DEPTH));
    assign w_push   = i_push & o_credit;
    assign w_pop    = i_pop & (r_count != '0);
    assign o_head   = r_mem[r_rd_ptr];
    assign o_count  = r_count;

    // Storage is not reset: reset empties the FIFO through the pointers/count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/input_buffer.sv
// input_buffer: per-port receive FIFO plus packet FSM of the router.
// Requests a route for the header at the FIFO head (h), waits for ack_h,
// then streams header, size and payload to the crossbar with sender high.
// Ports:
//   clock, reset      - rising-edge clock, async active-low reset
//   rx, data_in       - incoming flit from the link
//   credit_o          - buffer has space for another flit
//   h, ack_h          - route request / grant with switch control
//   data_av, data     - flit offered to the crossbar
//   data_ack          - crossbar consumed data this cycle
//   sender            - packet transmission in progress
//
// state     | meaning
// S_IDLE    | no packet in flight, waiting for a stored flit
// S_REQ     | header at head, h raised, waiting for ack_h
// S_HDR     | offering the header flit
// S_SIZE    | offering the size flit, loads the payload counter
// S_PAYLOAD | offering payload flits, counter counts down
// S_END     | last flit gone, sender drops
`timescale 1ns/1ps
module input_buffer
    import input_buffer_pkg::*;
#(
    parameter int TAM_FLIT   = input_buffer_pkg::TAM_FLIT,
    parameter int TAM_BUFFER = input_buffer_pkg::TAM_BUFFER
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rx,
    input  logic [TAM_FLIT-1:0] data_in,
    output logic                credit_o,
    output logic                h,
    input  logic                ack_h,
    output logic                data_av,
    output logic [TAM_FLIT-1:0] data,
    input  logic                data_ack,
    output logic                sender
);

    localparam int CW = $clog2(TAM_BUFFER+1);

    buf_state_t          r_state, w_state_nxt;
    logic                r_h, w_h_nxt;
    logic                r_sender, w_sender_nxt;
    logic [TAM_FLIT-1:0] r_cnt, w_cnt_nxt;
    logic                r_avail;
    logic [CW-1:0]       w_count;
    logic [TAM_FLIT-1:0] w_head;
    logic                w_pop;

    input_buffer_fifo #(
        .WIDTH (TAM_FLIT),
        .DEPTH (TAM_BUFFER)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .i_push   (rx),
        .i_data   (data_in),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_count  (w_count),
        .o_credit (credit_o)
    );

    assign data    = w_head;
    assign data_av = ((r_state == S_HDR) || (r_state == S_SIZE) || (r_state == S_PAYLOAD))
                     && (w_count != '0);
    assign w_pop   = data_av & data_ack;
    assign h       = r_h;
    assign sender  = r_sender;

    // IDLE looks at a registered not-empty flag, so h rises two edges after
    // the first write. No pops happen in S_END/S_IDLE, so the flag cannot be
    // stale in the direction that matters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_h      <= 1'b0;
            r_sender <= 1'b0;
            r_cnt    <= '0;
            r_avail  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_h      <= w_h_nxt;
            r_sender <= w_sender_nxt;
            r_cnt    <= w_cnt_nxt;
            r_avail  <= (w_count != '0);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_h_nxt      = r_h;
        w_sender_nxt = r_sender;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (r_avail) begin
                    w_state_nxt = S_REQ;
                    w_h_nxt     = 1'b1;
                end
            end
            S_REQ: begin
                if (ack_h) begin
                    w_state_nxt  = S_HDR;
                    w_h_nxt      = 1'b0;
                    w_sender_nxt = 1'b1;
                end
            end
            S_HDR: begin
                if (w_pop) w_state_nxt = S_SIZE;
            end
            S_SIZE: begin
                if (w_pop) begin
                    w_cnt_nxt   = w_head;
                    w_state_nxt = (w_head == '0) ? S_END : S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_pop) begin
                    w_cnt_nxt = r_cnt - TAM_FLIT'(1);
                    if (r_cnt == TAM_FLIT'(1)) w_state_nxt = S_END;
                end
            end
            S_END: begin
                w_sender_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_h_nxt      = 1'b0;
                w_sender_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_input_buffer.sv
`timescale 1ns/1ps
module tb_input_buffer;

    logic        clock;
    logic        reset;
    logic        rx;
    logic [15:0] data_in;
    logic        credit_o;
    logic        h;
    logic        ack_h;
    logic        data_av;
    logic [15:0] data;
    logic        data_ack;
    logic        sender;

    int tests_run    = 0;
    int tests_failed = 0;
    int viol         = 0;

    input_buffer dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .data_in  (data_in),
        .credit_o (credit_o),
        .h        (h),
        .ack_h    (ack_h),
        .data_av  (data_av),
        .data     (data),
        .data_ack (data_ack),
        .sender   (sender)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // rx while full is a protocol violation; counted so the full test can
    // confirm exactly one was forced.
    always @(posedge clock) begin
        if (reset && rx && !credit_o) viol++;
    end

    // All tasks start and end right after a falling edge.
    task automatic write_flit(input logic [15:0] d);
        rx = 1'b1;
        data_in = d;
        @(negedge clock);
        rx = 1'b0;
    endtask

    task automatic wait_h(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (h) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic grant();
        ack_h = 1'b1;
        @(negedge clock);
        ack_h = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        tests_run++;
        if (h !== 1'b0 || sender !== 1'b0 || data_av !== 1'b0 || credit_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_init: h=%b sender=%b data_av=%b credit_o=%b, want 0 0 0 1",
                     h, sender, data_av, credit_o);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single();
        logic [15:0] exp [4];
        bit ok;
        exp = '{16'h0011, 16'h0002, 16'hAAAA, 16'hBBBB};
        data_ack = 1'b1;
        write_flit(exp[0]);
        write_flit(exp[1]);
        tests_run++;
        if (h !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_h_early: h=%b, want 0 one edge after first write", h);
        end
        write_flit(exp[2]);
        tests_run++;
        if (h !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_h_latency: h=%b, want 1 two edges after first write", h);
        end
        write_flit(exp[3]);
        wait_h(ok);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            tests_run++;
            if (h !== 1'b1 || sender !== 1'b0) begin
                tests_failed++;
                $display("FAIL single_h_hold[%0d]: h=%b sender=%b, want 1 0", i, h, sender);
            end
        end
        grant();
        tests_run++;
        if (h !== 1'b0 || sender !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_grant: h=%b sender=%b, want 0 1", h, sender);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (data_av !== 1'b1 || data !== exp[i]) begin
                tests_failed++;
                $display("FAIL single_data[%0d]: data_av=%b data=%h, want 1 %h", i, data_av, data, exp[i]);
            end
            @(negedge clock);
        end
        @(negedge clock);
        tests_run++;
        if (sender !== 1'b0 || data_av !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_sender_fall: sender=%b data_av=%b, want 0 0", sender, data_av);
        end
    endtask

    task automatic test_full();
        logic [15:0] exp [3];
        bit ok;
        exp = '{16'h0002, 16'h5555, 16'h6666};
        data_ack = 1'b0;
        write_flit(16'h0033);
        write_flit(16'h0002);
        write_flit(16'h5555);
        tests_run++;
        if (credit_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_credit3: credit_o=%b, want 1", credit_o);
        end
        write_flit(16'h6666);
        tests_run++;
        if (credit_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_credit4: credit_o=%b, want 0", credit_o);
        end
        write_flit(16'hDEAD);
        tests_run++;
        if (dut.u_fifo.r_count !== 3'd4 || credit_o !== 1'b0 || viol !== 1) begin
            tests_failed++;
            $display("FAIL full_forced_rx: count=%0d credit_o=%b viol=%0d, want 4 0 1",
                     dut.u_fifo.r_count, credit_o, viol);
        end
        wait_h(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL full_h_timeout: h=%b, want 1", h);
        end
        grant();
        tests_run++;
        if (data !== 16'h0033 || data_av !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_hdr: data=%h data_av=%b, want 0033 1", data, data_av);
        end
        data_ack = 1'b1;
        @(negedge clock);
        tests_run++;
        if (credit_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_credit_back: credit_o=%b, want 1", credit_o);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (data_av !== 1'b1 || data !== exp[i]) begin
                tests_failed++;
                $display("FAIL full_data[%0d]: data_av=%b data=%h, want 1 %h", i, data_av, data, exp[i]);
            end
            @(negedge clock);
        end
        @(negedge clock);
        tests_run++;
        if (sender !== 1'b0 || dut.u_fifo.r_count !== 3'd0) begin
            tests_failed++;
            $display("FAIL full_end: sender=%b count=%0d, want 0 0", sender, dut.u_fifo.r_count);
        end
    endtask

    task automatic test_zero_size();
        bit ok;
        data_ack = 1'b1;
        write_flit(16'h0022);
        write_flit(16'h0000);
        wait_h(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL zero_h_timeout: h=%b, want 1", h);
        end
        grant();
        tests_run++;
        if (data !== 16'h0022 || data_av !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_hdr: data=%h data_av=%b, want 0022 1", data, data_av);
        end
        @(negedge clock);
        tests_run++;
        if (data !== 16'h0000 || data_av !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_size: data=%h data_av=%b, want 0000 1", data, data_av);
        end
        @(negedge clock);
        tests_run++;
        if (data_av !== 1'b0 || sender !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_end: data_av=%b sender=%b, want 0 1", data_av, sender);
        end
        @(negedge clock);
        tests_run++;
        if (sender !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_sender_fall: sender=%b, want 0", sender);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [3];
        bit ok;
        int low;
        exp = '{16'h0055, 16'h0001, 16'h8888};
        low = 0;
        ok = 1'b0;
        data_ack = 1'b1;
        write_flit(16'h0044);
        write_flit(16'h0001);
        write_flit(16'h7777);
        write_flit(16'h0055);
        wait_h(ok);
        grant();
        tests_run++;
        if (data !== 16'h0044) begin
            tests_failed++;
            $display("FAIL b2b_hdr1: data=%h, want 0044", data);
        end
        @(negedge clock);
        tests_run++;
        if (data !== 16'h0001) begin
            tests_failed++;
            $display("FAIL b2b_size1: data=%h, want 0001", data);
        end
        rx = 1'b1;
        data_in = 16'h0001;
        @(negedge clock);
        tests_run++;
        if (data !== 16'h7777 || sender !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_pay1: data=%h sender=%b, want 7777 1", data, sender);
        end
        data_in = 16'h8888;
        @(negedge clock);
        rx = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (sender === 1'b0) begin
                low++;
                if (low == 1) begin
                    tests_run++;
                    if (h !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL b2b_h_early: h=%b in first sender-low cycle, want 0", h);
                    end
                end
            end
            if (h === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!ok || low < 2) begin
            tests_failed++;
            $display("FAIL b2b_gap: h_seen=%b sender_low_cycles=%0d, want 1 and >=2", ok, low);
        end
        grant();
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (data_av !== 1'b1 || data !== exp[i]) begin
                tests_failed++;
                $display("FAIL b2b_data2[%0d]: data_av=%b data=%h, want 1 %h", i, data_av, data, exp[i]);
            end
            @(negedge clock);
        end
        @(negedge clock);
        tests_run++;
        if (sender !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: sender=%b, want 0", sender);
        end
    endtask

    task automatic test_stall();
        bit ok;
        data_ack = 1'b0;
        write_flit(16'h0066);
        write_flit(16'h0003);
        write_flit(16'h1111);
        write_flit(16'h2222);
        wait_h(ok);
        grant();
        tests_run++;
        if (data !== 16'h0066) begin
            tests_failed++;
            $display("FAIL stall_hdr: data=%h, want 0066", data);
        end
        data_ack = 1'b1;
        @(negedge clock);
        tests_run++;
        if (data !== 16'h0003) begin
            tests_failed++;
            $display("FAIL stall_size: data=%h, want 0003", data);
        end
        @(negedge clock);
        tests_run++;
        if (data !== 16'h1111 || dut.r_cnt !== 16'd3) begin
            tests_failed++;
            $display("FAIL stall_pay1: data=%h cnt=%0d, want 1111 3", data, dut.r_cnt);
        end
        @(negedge clock);
        data_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            tests_run++;
            if (data !== 16'h2222 || data_av !== 1'b1 || sender !== 1'b1 || dut.r_cnt !== 16'd2) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: data=%h data_av=%b sender=%b cnt=%0d, want 2222 1 1 2",
                         i, data, data_av, sender, dut.r_cnt);
            end
        end
        data_ack = 1'b1;
        @(negedge clock);
        tests_run++;
        if (data_av !== 1'b0 || sender !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_empty: data_av=%b sender=%b, want 0 1", data_av, sender);
        end
        write_flit(16'h3333);
        tests_run++;
        if (data_av !== 1'b1 || data !== 16'h3333) begin
            tests_failed++;
            $display("FAIL stall_pay3: data_av=%b data=%h, want 1 3333", data_av, data);
        end
        @(negedge clock);
        @(negedge clock);
        tests_run++;
        if (sender !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_end: sender=%b, want 0", sender);
        end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        data_ack = 1'b0;
        write_flit(16'h0077);
        write_flit(16'h0002);
        write_flit(16'hAAAA);
        wait_h(ok);
        grant();
        data_ack = 1'b1;
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (h !== 1'b0 || sender !== 1'b0 || data_av !== 1'b0 || credit_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid: h=%b sender=%b data_av=%b credit_o=%b, want 0 0 0 1",
                     h, sender, data_av, credit_o);
        end
        data_ack = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            tests_run++;
            if (data_av !== 1'b0 || h !== 1'b0 || sender !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_stale[%0d]: data_av=%b h=%b sender=%b, want 0 0 0",
                         i, data_av, h, sender);
            end
        end
    endtask

    initial begin
        rx       = 1'b0;
        data_in  = '0;
        ack_h    = 1'b0;
        data_ack = 1'b0;
        reset    = 1'b0;
        @(negedge clock);
        test_reset();
        test_single();
        test_full();
        test_zero_size();
        test_back_to_back();
        test_stall();
        test_reset_mid_packet();
        tests_run++;
        if (viol !== 1) begin
            tests_failed++;
            $display("FAIL protocol_viol_count: viol=%0d, want 1", viol);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
